// File: rtl/dram_burst_responder_pkg.sv
// Shared definitions for the DRAM burst responder: DDR command encodings,
// the memory index position inside the burst address, and the FSM state type.
package dram_burst_responder_pkg;

  typedef enum logic [0:0] {
    StInit = 1'b0,
    StRun  = 1'b1
  } respState_t;

  localparam logic [2:0] DDRCmdWrite = 3'b000;
  localparam logic [2:0] DDRCmdRead  = 3'b001;

  // Address bits below this position select bytes inside one burst
  localparam int MemIndexLSB = 3;

  // Byte-mask width for a given data beat width
  function automatic int ddrMWidth(input int dWidth);
    return dWidth / 8;
  endfunction

endpackage

// File: rtl/dram_burst_responder_resp_sync_fifo.sv
// Parameterized synchronous FIFO with registered occupancy count.
// Depth must be a power of two (>= 2) so the pointers wrap naturally.
// Push while full and pop while empty are ignored.
module resp_sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic                     push,
  input  logic [Width-1:0]         pushData,
  input  logic                     pop,
  output logic [Width-1:0]         popData,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  logic [Width-1:0] store_r [Depth];
  logic [AW-1:0]    wrPtr_r;
  logic [AW-1:0]    rdPtr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             empty_s;
  logic             doPush_s;
  logic             doPop_s;

  assign full_s   = (count_r == CW'(Depth));
  assign empty_s  = (count_r == {CW{1'b0}});
  assign doPush_s = push && !full_s;
  assign doPop_s  = pop && !empty_s;

  // Storage array; no reset needed since occupancy gates every read
  always_ff @(posedge Clock) begin
    if (doPush_s) begin
      store_r[wrPtr_r] <= pushData;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wrPtr_r <= {AW{1'b0}};
      rdPtr_r <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (doPush_s) wrPtr_r <= wrPtr_r + AW'(1);
      if (doPop_s)  rdPtr_r <= rdPtr_r + AW'(1);
      case ({doPush_s, doPop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign popData = store_r[rdPtr_r];
  assign empty   = empty_s;
  assign count   = count_r;

endmodule

// File: rtl/dram_burst_responder.sv
// DRAM-side responder standing in for a MIG controller plus DDR3 device.
// Commands and write beats are queued separately and paired in order; the
// head command executes one per cycle against an on-chip burst memory, and
// reads return through a fixed-latency pipeline with no backpressure.
// Optional build macro: DRAM_RESP_STALL_INJECT_EN adds LFSR-driven random
// deassertion of both Ready outputs to exercise initiator backpressure.
module dram_burst_responder
  import dram_burst_responder_pkg::*;
#(
  parameter int DDRDWidth    = 512,
  parameter int DDRAWidth    = 28,
  parameter int DDRCWidth    = 3,
  parameter int MemDepthLog  = 10,
  parameter int ReadLatency  = 8,
  parameter int CmdFIFODepth = 4,
  parameter int WDFIFODepth  = 8
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic [DDRAWidth-1:0]   DRAMAddress,
  input  logic [DDRCWidth-1:0]   DRAMCommand,
  input  logic                   DRAMCommandValid,
  output logic                   DRAMCommandReady,
  input  logic [DDRDWidth-1:0]   DRAMWriteData,
  input  logic [DDRDWidth/8-1:0] DRAMWriteMask,
  input  logic                   DRAMWriteDataValid,
  output logic                   DRAMWriteDataReady,
  output logic [DDRDWidth-1:0]   DRAMReadData,
  output logic                   DRAMReadDataValid,
  output logic                   InitComplete,
  output logic                   ProtocolError
);

  localparam int DDRMWidth  = ddrMWidth(DDRDWidth);
  localparam int CmdW       = DDRCWidth + MemDepthLog;
  localparam int WdW        = DDRDWidth + DDRMWidth;
  localparam int MemEntries = 1 << MemDepthLog;
  localparam int CmdCntW    = $clog2(CmdFIFODepth) + 1;
  localparam int WdCntW     = $clog2(WDFIFODepth) + 1;
  localparam logic [DDRCWidth-1:0] CmdWrite = DDRCWidth'(DDRCmdWrite);
  localparam logic [DDRCWidth-1:0] CmdRead  = DDRCWidth'(DDRCmdRead);

  respState_t             state_r;
  logic [MemDepthLog-1:0] sweep_r;
  logic                   initComplete_r;
  logic                   protocolError_r;

  logic [DDRDWidth-1:0]   mem_r [MemEntries];
  logic [ReadLatency-1:0] pipeValid_r;
  logic [DDRDWidth-1:0]   pipeData_r [ReadLatency];

  logic [CmdW-1:0]        cmdHead_s;
  logic [WdW-1:0]         wdHead_s;
  logic                   cmdEmpty_s;
  logic                   wdEmpty_s;
  logic [CmdCntW-1:0]     cmdCount_s;
  logic [WdCntW-1:0]      wdCount_s;
  logic                   cmdFull_s;
  logic                   wdFull_s;
  logic                   cmdPush_s;
  logic                   wdPush_s;
  logic                   cmdPop_s;
  logic                   wdPop_s;
  logic                   stall_s;
  logic [DDRCWidth-1:0]   headCmd_s;
  logic [MemDepthLog-1:0] headIdx_s;
  logic [DDRDWidth-1:0]   headData_s;
  logic [DDRMWidth-1:0]   headMask_s;
  logic                   execRead_s;
  logic                   execWrite_s;
  logic                   execIllegal_s;
  logic                   unusedAddr_s;

  // Only the index bits select an entry; the rest alias or address bytes
  assign unusedAddr_s = ^DRAMAddress;

`ifdef DRAM_RESP_STALL_INJECT_EN
  logic [15:0] lfsr_r;

  // Pseudo-random stall source, advancing once per RUN cycle
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      lfsr_r <= 16'hACE1;
    end else if (state_r == StRun) begin
      lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign stall_s = (lfsr_r[1:0] == 2'b00);
`else
  assign stall_s = 1'b0;
`endif

  // Ready is built only from registered state so a same-cycle pop never
  // opens a slot until the following cycle
  assign cmdFull_s          = (cmdCount_s == CmdCntW'(CmdFIFODepth));
  assign wdFull_s           = (wdCount_s == WdCntW'(WDFIFODepth));
  assign DRAMCommandReady   = (state_r == StRun) && !cmdFull_s && !stall_s;
  assign DRAMWriteDataReady = (state_r == StRun) && !wdFull_s && !stall_s;
  assign cmdPush_s          = DRAMCommandValid && DRAMCommandReady;
  assign wdPush_s           = DRAMWriteDataValid && DRAMWriteDataReady;

  resp_sync_fifo #(.Width(CmdW), .Depth(CmdFIFODepth)) cmdFifo (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .push     (cmdPush_s),
    .pushData ({DRAMCommand, DRAMAddress[MemIndexLSB +: MemDepthLog]}),
    .pop      (cmdPop_s),
    .popData  (cmdHead_s),
    .empty    (cmdEmpty_s),
    .count    (cmdCount_s)
  );

  resp_sync_fifo #(.Width(WdW), .Depth(WDFIFODepth)) wdFifo (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .push     (wdPush_s),
    .pushData ({DRAMWriteData, DRAMWriteMask}),
    .pop      (wdPop_s),
    .popData  (wdHead_s),
    .empty    (wdEmpty_s),
    .count    (wdCount_s)
  );

  assign headCmd_s  = cmdHead_s[CmdW-1:MemDepthLog];
  assign headIdx_s  = cmdHead_s[MemDepthLog-1:0];
  assign headData_s = wdHead_s[WdW-1:DDRMWidth];
  assign headMask_s = wdHead_s[DDRMWidth-1:0];

  // Decide what the head command does this cycle; a write without its beat
  // stalls the whole in-order queue
  always_comb begin
    execRead_s    = 1'b0;
    execWrite_s   = 1'b0;
    execIllegal_s = 1'b0;
    if ((state_r == StRun) && !cmdEmpty_s) begin
      case (headCmd_s)
        CmdWrite: execWrite_s   = !wdEmpty_s;
        CmdRead:  execRead_s    = 1'b1;
        default:  execIllegal_s = 1'b1;
      endcase
    end else begin
      execRead_s    = 1'b0;
      execWrite_s   = 1'b0;
      execIllegal_s = 1'b0;
    end
  end

  assign cmdPop_s = execRead_s || execWrite_s || execIllegal_s;
  assign wdPop_s  = execWrite_s;

  // Control FSM: zero sweep in INIT, then serve traffic; also the sticky error
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r         <= StInit;
      sweep_r         <= {MemDepthLog{1'b0}};
      initComplete_r  <= 1'b0;
      protocolError_r <= 1'b0;
    end else begin
      case (state_r)
        StInit: begin
          sweep_r <= sweep_r + MemDepthLog'(1);
          if (sweep_r == {MemDepthLog{1'b1}}) state_r <= StRun;
        end
        StRun:   state_r <= StRun;
        default: state_r <= StInit;
      endcase
      initComplete_r <= (state_r == StRun);
      if (execIllegal_s) protocolError_r <= 1'b1;
    end
  end

  // Burst memory: cleared entry by entry during INIT, byte-masked writes in RUN
  always_ff @(posedge Clock) begin
    if (state_r == StInit) begin
      mem_r[sweep_r] <= {DDRDWidth{1'b0}};
    end else if (execWrite_s) begin
      for (int i = 0; i < DDRMWidth; i++) begin
        if (!headMask_s[i]) mem_r[headIdx_s][8*i +: 8] <= headData_s[8*i +: 8];
      end
    end
  end

  // Read return pipeline; its last stage drives the outputs directly
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pipeValid_r <= {ReadLatency{1'b0}};
      for (int i = 0; i < ReadLatency; i++) pipeData_r[i] <= {DDRDWidth{1'b0}};
    end else begin
      pipeValid_r   <= {pipeValid_r[ReadLatency-2:0], execRead_s};
      pipeData_r[0] <= execRead_s ? mem_r[headIdx_s] : {DDRDWidth{1'b0}};
      for (int i = 1; i < ReadLatency; i++) pipeData_r[i] <= pipeData_r[i-1];
    end
  end

  assign DRAMReadData      = pipeData_r[ReadLatency-1];
  assign DRAMReadDataValid = pipeValid_r[ReadLatency-1];
  assign InitComplete      = initComplete_r;
  assign ProtocolError     = protocolError_r;

endmodule

// File: tb/tb_dram_burst_responder.sv
// Directed bench for dram_burst_responder with default parameters.
module tb_dram_burst_responder;

  localparam logic [2:0] WR = 3'b000;
  localparam logic [2:0] RD = 3'b001;

  logic         Clock = 1'b0;
  logic         Reset_n = 1'b0;
  logic [27:0]  DRAMAddress = '0;
  logic [2:0]   DRAMCommand = '0;
  logic         DRAMCommandValid = 1'b0;
  logic         DRAMCommandReady;
  logic [511:0] DRAMWriteData = '0;
  logic [63:0]  DRAMWriteMask = '0;
  logic         DRAMWriteDataValid = 1'b0;
  logic         DRAMWriteDataReady;
  logic [511:0] DRAMReadData;
  logic         DRAMReadDataValid;
  logic         InitComplete;
  logic         ProtocolError;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  dram_burst_responder dut (
    .Clock              (Clock),
    .Reset_n            (Reset_n),
    .DRAMAddress        (DRAMAddress),
    .DRAMCommand        (DRAMCommand),
    .DRAMCommandValid   (DRAMCommandValid),
    .DRAMCommandReady   (DRAMCommandReady),
    .DRAMWriteData      (DRAMWriteData),
    .DRAMWriteMask      (DRAMWriteMask),
    .DRAMWriteDataValid (DRAMWriteDataValid),
    .DRAMWriteDataReady (DRAMWriteDataReady),
    .DRAMReadData       (DRAMReadData),
    .DRAMReadDataValid  (DRAMReadDataValid),
    .InitComplete       (InitComplete),
    .ProtocolError      (ProtocolError)
  );

  task automatic apply_reset();
    Reset_n = 1'b0;
    DRAMCommandValid = 1'b0;
    DRAMWriteDataValid = 1'b0;
    repeat (3) @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!InitComplete && n < 2000) begin
      @(posedge Clock); #1;
      n++;
    end
  endtask

  task automatic send_cmd(input logic [2:0] cmd, input logic [27:0] addr);
    int n = 0;
    @(negedge Clock);
    DRAMCommand = cmd;
    DRAMAddress = addr;
    DRAMCommandValid = 1'b1;
    while (!DRAMCommandReady && n < 200) begin
      @(negedge Clock);
      n++;
    end
    if (!DRAMCommandReady) begin
      checks++; errors++;
      $display("FAIL cmd_accept_timeout ready=%0b want 1", DRAMCommandReady);
      DRAMCommandValid = 1'b0;
    end else begin
      @(posedge Clock); #1;
      DRAMCommandValid = 1'b0;
    end
  endtask

  task automatic send_wd(input logic [511:0] data, input logic [63:0] mask);
    int n = 0;
    @(negedge Clock);
    DRAMWriteData = data;
    DRAMWriteMask = mask;
    DRAMWriteDataValid = 1'b1;
    while (!DRAMWriteDataReady && n < 200) begin
      @(negedge Clock);
      n++;
    end
    if (!DRAMWriteDataReady) begin
      checks++; errors++;
      $display("FAIL wd_accept_timeout ready=%0b want 1", DRAMWriteDataReady);
      DRAMWriteDataValid = 1'b0;
    end else begin
      @(posedge Clock); #1;
      DRAMWriteDataValid = 1'b0;
    end
  endtask

  // Issues a read; cyc is the cycle index (acceptance cycle = 0) of the return
  task automatic do_read(input logic [27:0] addr, output logic [511:0] data, output int cyc);
    send_cmd(RD, addr);
    cyc = 1;
    while (!DRAMReadDataValid && cyc < 100) begin
      @(posedge Clock); #1;
      cyc++;
    end
    data = DRAMReadDataValid ? DRAMReadData : {512{1'bx}};
  endtask

  task automatic test_reset();
    int n;
    logic [511:0] d;
    int cyc;
    Reset_n = 1'b0;
    #2;
    checks++;
    if ({DRAMCommandReady, DRAMWriteDataReady, DRAMReadDataValid, InitComplete, ProtocolError} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000",
               {DRAMCommandReady, DRAMWriteDataReady, DRAMReadDataValid, InitComplete, ProtocolError});
    end
    checks++;
    if (DRAMReadData !== 512'h0) begin
      errors++;
      $display("FAIL reset_read_data got %h want 0", DRAMReadData);
    end
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
    n = 0;
    while (!InitComplete && n < 2000) begin
      @(posedge Clock); #1;
      n++;
      if (n == 500) begin
        checks++;
        if ({DRAMCommandReady, DRAMWriteDataReady} !== 2'b00) begin
          errors++;
          $display("FAIL init_ready got %b want 00", {DRAMCommandReady, DRAMWriteDataReady});
        end
      end
    end
    checks++;
    if (n != 1025) begin
      errors++;
      $display("FAIL init_complete_cycles got %0d want 1025", n);
    end
    do_read(28'h0000040, d, cyc);
    checks++;
    if (d !== 512'h0) begin
      errors++;
      $display("FAIL zero_read got %h want 0", d);
    end
  endtask

  task automatic test_full_write();
    logic [511:0] d;
    int cyc;
    send_cmd(WR, 28'h0000008);
    send_wd({64{8'hA5}}, 64'h0);
    do_read(28'h0000008, d, cyc);
    checks++;
    if (cyc != 9) begin
      errors++;
      $display("FAIL read_latency got %0d want 9", cyc);
    end
    checks++;
    if (d !== {64{8'hA5}}) begin
      errors++;
      $display("FAIL full_write_data got %h want %h", d, {64{8'hA5}});
    end
  endtask

  task automatic test_masked_write();
    logic [511:0] d;
    int cyc;
    send_cmd(WR, 28'h0000008);
    send_wd({64{8'h5A}}, 64'h00000000_0000FFFF);
    do_read(28'h0000008, d, cyc);
    checks++;
    if (d !== {{48{8'h5A}}, {16{8'hA5}}}) begin
      errors++;
      $display("FAIL masked_write_data got %h want %h", d, {{48{8'h5A}}, {16{8'hA5}}});
    end
  endtask

  task automatic test_blocked_writes();
    logic [511:0] beats [4];
    logic [511:0] d;
    int cyc;
    beats[0] = {64{8'h11}};
    beats[1] = {64{8'h22}};
    beats[2] = {64{8'h33}};
    beats[3] = {64{8'h44}};
    for (int k = 0; k < 4; k++) send_cmd(WR, 28'h0000100 + 28'(8 * k));
    repeat (2) @(negedge Clock);
    checks++;
    if ({DRAMCommandReady, DRAMWriteDataReady} !== 2'b01) begin
      errors++;
      $display("FAIL cmd_fifo_full got %b want 01", {DRAMCommandReady, DRAMWriteDataReady});
    end
    send_wd(beats[0], 64'h0);
    send_cmd(RD, 28'h0000118);
    for (int k = 1; k < 4; k++) send_wd(beats[k], 64'h0);
    cyc = 0;
    while (!DRAMReadDataValid && cyc < 100) begin
      @(posedge Clock); #1;
      cyc++;
    end
    checks++;
    if (!DRAMReadDataValid || DRAMReadData !== beats[3]) begin
      errors++;
      $display("FAIL queued_read valid=%0b got %h want %h", DRAMReadDataValid, DRAMReadData, beats[3]);
    end
    for (int k = 0; k < 4; k++) begin
      do_read(28'h0000100 + 28'(8 * k), d, cyc);
      checks++;
      if (d !== beats[k]) begin
        errors++;
        $display("FAIL blocked_write_%0d got %h want %h", k, d, beats[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] got [3];
    int pos [3];
    int nv = 0;
    send_cmd(RD, 28'h0000100);
    send_cmd(RD, 28'h0000108);
    send_cmd(RD, 28'h0000110);
    for (int c = 0; c < 20; c++) begin
      @(posedge Clock); #1;
      if (DRAMReadDataValid) begin
        if (nv < 3) begin
          got[nv] = DRAMReadData;
          pos[nv] = c;
        end
        nv++;
      end
    end
    checks++;
    if (nv != 3) begin
      errors++;
      $display("FAIL b2b_count got %0d want 3", nv);
    end else begin
      checks++;
      if (pos[2] - pos[0] != 2) begin
        errors++;
        $display("FAIL b2b_spacing got %0d want 2", pos[2] - pos[0]);
      end
      checks++;
      if (got[0] !== {64{8'h11}} || got[1] !== {64{8'h22}} || got[2] !== {64{8'h33}}) begin
        errors++;
        $display("FAIL b2b_data got %h %h %h", got[0][7:0], got[1][7:0], got[2][7:0]);
      end
    end
  endtask

  task automatic test_protocol_error();
    logic [511:0] d;
    int cyc;
    int n;
    send_cmd(3'b111, 28'h0000000);
    repeat (2) @(posedge Clock);
    #1;
    checks++;
    if (ProtocolError !== 1'b1) begin
      errors++;
      $display("FAIL protocol_error_set got %b want 1", ProtocolError);
    end
    do_read(28'h0000008, d, cyc);
    checks++;
    if (d !== {{48{8'h5A}}, {16{8'hA5}}}) begin
      errors++;
      $display("FAIL read_after_error got %h want %h", d, {{48{8'h5A}}, {16{8'hA5}}});
    end
    checks++;
    if (ProtocolError !== 1'b1) begin
      errors++;
      $display("FAIL protocol_error_sticky got %b want 1", ProtocolError);
    end
    apply_reset();
    #1;
    checks++;
    if (ProtocolError !== 1'b0) begin
      errors++;
      $display("FAIL protocol_error_cleared got %b want 0", ProtocolError);
    end
    wait_init(n);
    checks++;
    if (InitComplete !== 1'b1) begin
      errors++;
      $display("FAIL reinit_after_error got %b want 1", InitComplete);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [511:0] d;
    int cyc;
    int n;
    int nv = 0;
    send_cmd(WR, 28'h0000100);
    send_wd({64{8'h77}}, 64'h0);
    send_cmd(RD, 28'h0000008);
    send_cmd(RD, 28'h0000100);
    send_cmd(RD, 28'h0000108);
    repeat (3) @(posedge Clock);
    #1;
    Reset_n = 1'b0;
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge Clock); #1;
      if (DRAMReadDataValid) nv++;
    end
    checks++;
    if (nv != 0) begin
      errors++;
      $display("FAIL no_valid_after_reset got %0d want 0", nv);
    end
    wait_init(n);
    checks++;
    if (n != 995) begin
      errors++;
      $display("FAIL reinit_cycles got %0d want 995", n);
    end
    do_read(28'h0000100, d, cyc);
    checks++;
    if (d !== 512'h0) begin
      errors++;
      $display("FAIL cleared_after_reset got %h want 0", d);
    end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_masked_write();
    test_blocked_writes();
    test_back_to_back();
    test_protocol_error();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_burst_responder.md
Name: dram_burst_responder

Overview:
- Synthesizable DRAM-side responder for the backend's MIG-style DRAM interface: accepts address/command, write data plus byte mask, and returns read data.
- Backs the interface with an on-chip burst memory.
- Stands in for MIG plus DDR3 under simulation and FPGA loopback, so the ORAM top runs with no external DRAM.
- One data beat (DDRDWidth bits) per command; no read backpressure, matching MIG.

Parameters:
- DDRDWidth, 512, data beat width.
- DDRAWidth, 28, command address width.
- DDRCWidth, 3, command width.
- MemDepthLog, 10, log2 of the number of stored bursts.
- ReadLatency, 8, cycles from read execution to DRAMReadDataValid; must be >= 2.
- CmdFIFODepth, 4, command queue entries (power of 2).
- WDFIFODepth, 8, write-data queue entries (power of 2).

Ports:
- Clock  in  1  sole clock.
- Reset_n  in  1  asynchronous, active-low reset.
- DRAMAddress  in  DDRAWidth  burst address; bits [2:0] are ignored.
- DRAMCommand  in  DDRCWidth  3'b000 = write, 3'b001 = read, any other value is illegal.
- DRAMCommandValid  in  1  command offered.
- DRAMCommandReady  out  1  command accepted when Valid && Ready.
- DRAMWriteData  in  DDRDWidth  write beat.
- DRAMWriteMask  in  DDRDWidth/8  a 1 bit means that byte is NOT written.
- DRAMWriteDataValid  in  1  write beat offered.
- DRAMWriteDataReady  out  1  write beat accepted when Valid && Ready.
- DRAMReadData  out  DDRDWidth  read beat.
- DRAMReadDataValid  out  1  single-cycle qualifier; the consumer cannot stall it.
- InitComplete  out  1  memory cleared and ready for traffic.
- ProtocolError  out  1  sticky flag, set by an illegal command.

Behaviour:
- Reset (async, Reset_n = 0): all outputs 0; both FIFOs, read pipeline and error flag cleared; FSM enters INIT. Reset mid-operation discards any in-flight reads, so no DRAMReadDataValid follows.
- FSM INIT:
  - Sweep counter writes zero to every memory entry, one entry per cycle.
  - After the 2^MemDepthLog-th write, go to RUN and set InitComplete = 1 on the next cycle.
  - Both Ready outputs stay 0 throughout INIT.
- FSM RUN:
  - DRAMCommandReady = !cmdFIFO full.
  - DRAMWriteDataReady = !wdFIFO full.
  - Memory index = DRAMAddress[MemDepthLog+2:3]. Higher address bits alias onto the same entries.
- Execution (one command per cycle, strictly in order, from the cmdFIFO head):
  - Read: pop the command, read memory, push {valid} into a ReadLatency-stage shift pipeline. Data appears ReadLatency cycles after the execute cycle.
  - Write: execute only when the wdFIFO is non-empty; pop both FIFOs together. Byte-enable write: byte i is updated iff mask[i] = 0. While the wdFIFO is empty, the head write blocks, and every later read behind it blocks too.
  - Illegal command: pop, no memory action, ProtocolError = 1 until reset.
- Ordering and timing:
  - A read always observes every earlier-accepted write; there is no forwarding hazard because memory is written in the execute cycle.
  - With empty queues, a read accepted at cycle t has DRAMReadDataValid at t + 1 + ReadLatency.
- Write data may arrive before, with, or after its command; it is paired in FIFO order. Excess beats (WDFIFODepth) backpressure through DRAMWriteDataReady.
- Simultaneous push and pop on a full FIFO is allowed: Ready is computed from the registered count, and pop frees space in the same cycle only for the next cycle's Ready.
- Back-to-back reads give one DRAMReadDataValid per cycle.

Optional Feature:
- Macro DRAM_RESP_STALL_INJECT_EN.
- When defined: a 16-bit LFSR (seed 16'hACE1, reloaded on reset, taps 16,14,13,11) advances every RUN cycle. DRAMCommandReady and DRAMWriteDataReady are forced to 0 on cycles where lfsr[1:0] == 2'b00, exercising initiator backpressure. Data ordering and latency rules are unchanged.
- When undefined: no LFSR, and Ready depends only on FIFO occupancy.

Decomposition:
- Shared package DRAMRespLocal.vh: DDR command encodings (write, read), DDRMWidth = DDRDWidth/8, MemIndexLSB = 3.
- Sub-module resp_sync_fifo: parameterized width/depth synchronous FIFO with full/empty/count, instantiated twice (command {cmd,index}, write data {data,mask}).
- The burst memory and read pipeline stay inline.

Test Plan:
- Reset release -> InitComplete rises exactly 1024 + 1 cycles later (MemDepthLog = 10); read of address 28'h0000040 returns all-zero data.
- Write data 512'hA5 repeated to address 28'h0000008 with mask 0, then read the same address -> DRAMReadDataValid exactly 1 + ReadLatency = 9 cycles after read acceptance, data = A5 pattern.
- Write with mask 64'h00000000_0000FFFF over prior A5 data, new data 5A -> read returns bytes 0–15 = A5, bytes 16–63 = 5A.
- Issue 4 write commands with no write data -> cmdFIFO fills, DRAMCommandReady = 0; supply 4 beats -> all commit in order; a following read of each address returns its beat; a read queued behind the blocked writes returns post-write data.
- DRAMCommand = 3'b111 -> ProtocolError = 1 and stays set; subsequent legal read still returns correct data; Reset_n pulse clears the flag.
- Issue 3 back-to-back reads, assert Reset_n = 0 mid-latency -> no DRAMReadDataValid after reset; INIT sweep reruns and memory reads back zero.
